// File: rtl/block_idx_fetch.sv
// Streams a run of block-index words from the bank through a 2-entry FIFO as PE-cluster masks.
// Read issue is credit-limited so the FIFO never overflows; the mask is held while blk_ready is low.
module block_idx_fetch #(
  parameter int N_PE_CLUSTER     = 20,
  parameter int DEPTH_BLOCK_BANK = 2048,
  localparam int AW              = $clog2(DEPTH_BLOCK_BANK)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AW-1:0]           base_addr,
  input  logic [AW:0]             num_blocks,
  output logic                    ren_block_idx_bank,
  output logic [AW-1:0]           raddr_block_idx_bank,
  input  logic [N_PE_CLUSTER-1:0] block_idx_data,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [N_PE_CLUSTER-1:0] blk_mask,
  output logic                    blk_any,
  output logic                    blk_last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH_BLOCK_BANK);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  state_t state_q, state_d;
  logic   done_q, done_d;

  logic [AW-1:0] base_q;
  logic [AW:0]   num_q, rd_cnt_q, xfer_cnt_q;
  logic          pend_q;

  logic [N_PE_CLUSTER-1:0] fifo_mem [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              occ_q;

  logic          start_ok, issue, push, pop, credit_ok;
  logic [AW:0]   addr_sum, addr_wrap;
  logic          addr_unused;

  assign start_ok  = (state_q == IDLE) && start;
  assign push      = pend_q;
  assign blk_valid = (occ_q != 2'd0);
  assign pop       = blk_valid && blk_ready;
  assign blk_mask  = blk_valid ? fifo_mem[rd_ptr_q] : '0;
  assign blk_any   = |blk_mask;
  assign blk_last  = blk_valid && ((xfer_cnt_q + ONE) == num_q);

  // A slot freed by this cycle's pop can be reused by this cycle's read.
  assign credit_ok = ({1'b0, occ_q} + {2'b0, pend_q}) < (3'd2 + {2'b0, pop});
  assign issue     = (state_q == FETCH) && (rd_cnt_q != num_q) && credit_ok;

  assign addr_sum    = {1'b0, base_q} + rd_cnt_q;
  assign addr_wrap   = (addr_sum >= DEPTH_L) ? (addr_sum - DEPTH_L) : addr_sum;
  assign addr_unused = addr_wrap[AW];

  assign ren_block_idx_bank   = issue;
  assign raddr_block_idx_bank = issue ? addr_wrap[AW-1:0] : '0;
  assign busy                 = (state_q != IDLE);
  assign done                 = done_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_blocks == '0) done_d  = 1'b1;
          else                  state_d = FETCH;
        end
      end
      FETCH: begin
        if (issue && ((rd_cnt_q + ONE) == num_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && blk_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      base_q     <= '0;
      num_q      <= '0;
      rd_cnt_q   <= '0;
      xfer_cnt_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      // Clearing pend_q on reset is what drops data from reads issued before it.
      pend_q  <= issue;
      if (start_ok) begin
        base_q     <= base_addr;
        num_q      <= num_blocks;
        rd_cnt_q   <= '0;
        xfer_cnt_q <= '0;
      end else begin
        if (issue) rd_cnt_q   <= rd_cnt_q + ONE;
        if (pop)   xfer_cnt_q <= xfer_cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= block_idx_data;
  end

endmodule

// File: tb/tb_block_idx_fetch.sv
// Directed bench for block_idx_fetch: a bank model answers reads, a scoreboard checks addresses and masks.
module tb_block_idx_fetch;
  localparam int N  = 20;
  localparam int D  = 2048;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst, start, blk_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_blocks;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [N-1:0]  block_idx_data;
  logic          blk_valid, blk_any, blk_last, busy, done;
  logic [N-1:0]  blk_mask;

  block_idx_fetch #(.N_PE_CLUSTER(N), .DEPTH_BLOCK_BANK(D)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
    .ren_block_idx_bank(ren), .raddr_block_idx_bank(raddr), .block_idx_data(block_idx_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_mask(blk_mask), .blk_any(blk_any),
    .blk_last(blk_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0] mem [D];
  always @(posedge clk) if (ren) block_idx_data <= mem[raddr];

  int           addr_q [$];
  logic [N-1:0] mask_q [$];
  logic [N-1:0] exp_m;
  int ren_cnt, x_cnt, last_cnt, done_cnt;
  int start_cyc, last_ren_cyc, first_x_cyc, last_x_cyc, done_cyc;
  bit busy_seen, prev_stall;
  logic [N+2:0] prev_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Monitor samples 1 time unit after the falling edge, after the stimulus for that cycle settles.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      ren_cnt = 0; x_cnt = 0; last_cnt = 0; done_cnt = 0;
      busy_seen = 0; prev_stall = 0;
    end else begin
      if (start && !busy) begin
        ren_cnt = 0; x_cnt = 0; last_cnt = 0; done_cnt = 0;
        busy_seen = 0; start_cyc = cyc;
      end
      if (busy) busy_seen = 1;
      if (prev_stall) chk("hold", 32'({blk_valid, blk_mask, blk_any, blk_last}), 32'(prev_out));
      if (ren) begin
        ren_cnt++;
        last_ren_cyc = cyc;
        if (addr_q.size() == 0) chk("ren_extra", 32'(ren), 32'(0));
        else                    chk("raddr", 32'(raddr), 32'(addr_q.pop_front()));
      end
      if (blk_valid && blk_ready) begin
        x_cnt++;
        if (x_cnt == 1) first_x_cyc = cyc;
        last_x_cyc = cyc;
        if (blk_last) last_cnt++;
        if (mask_q.size() == 0) chk("xfer_extra", 32'(blk_valid), 32'(0));
        else begin
          exp_m = mask_q.pop_front();
          chk("mask", 32'(blk_mask), 32'(exp_m));
          chk("any", 32'(blk_any), 32'(|exp_m));
          chk("last", 32'(blk_last), 32'(mask_q.size() == 0));
        end
      end
      if (ren) chk("credit", 32'((ren_cnt - x_cnt) <= 2), 32'(1));
      prev_stall = blk_valid && !blk_ready;
      prev_out   = {blk_valid, blk_mask, blk_any, blk_last};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic launch(input int b, input int n);
    int a;
    for (int k = 0; k < n; k++) begin
      a = (b + k) % D;
      addr_q.push_back(a);
      mask_q.push_back(mem[a]);
    end
    base_addr  = AW'(b);
    num_blocks = (AW+1)'(n);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic finish_run(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != 0) break;
    end
    repeat (2) @(negedge clk);
    chk("done_once", 32'(done_cnt), 32'(1));
    chk("ren_count", 32'(ren_cnt), 32'(n));
    chk("xfer_count", 32'(x_cnt), 32'(n));
    chk("last_count", 32'(last_cnt), 32'(n != 0));
    chk("busy_end", 32'(busy), 32'(0));
    chk("sb_empty", 32'(addr_q.size() + mask_q.size()), 32'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({ren, blk_valid, blk_any, blk_last, busy, done}), 32'(0));
    chk("zero_raddr", 32'(raddr), 32'(0));
    chk("zero_mask", 32'(blk_mask), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < D; i++) mem[i] = N'((i * 40503) ^ 32'h3C5A5);
    mem[100]   = 20'h00000;
    mem[101]   = 20'h80001;
    rst        = 1'b1;
    start      = 1'b0;
    blk_ready  = 1'b1;
    base_addr  = '0;
    num_blocks = '0;
    #1;
    chk_zero("reset_ctl");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic run: 4 reads back to back, 4 transfers back to back, done after the last.
    launch(5, 4);
    finish_run(4, 50);
    chk("t_last_ren", 32'(last_ren_cyc - start_cyc), 32'(4));
    chk("t_first_x", 32'(first_x_cyc - start_cyc), 32'(3));
    chk("t_last_x", 32'(last_x_cyc - start_cyc), 32'(6));
    chk("t_done", 32'(done_cyc - start_cyc), 32'(7));

    // Address wrap at the top of the bank.
    launch(2046, 4);
    finish_run(4, 50);

    // Downstream stalled for 6 cycles after start.
    blk_ready = 1'b0;
    launch(10, 4);
    repeat (5) @(negedge clk);
    chk("stall_reads", 32'(ren_cnt), 32'(2));
    chk("stall_xfers", 32'(x_cnt), 32'(0));
    chk("stall_valid", 32'(blk_valid), 32'(1));
    blk_ready = 1'b1;
    finish_run(4, 50);

    // Empty run.
    launch(7, 0);
    finish_run(0, 20);
    chk("zero_done_t", 32'(done_cyc - start_cyc), 32'(1));
    chk("zero_busy", 32'(busy_seen), 32'(0));

    // Zero and sparse masks, plus a second start mid-run that must be ignored.
    launch(100, 3);
    base_addr  = AW'(500);
    num_blocks = (AW+1)'(9);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    finish_run(3, 50);

    // Reset after two reads of a 10-word run, then a clean run.
    launch(300, 10);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_reads", 32'(ren_cnt), 32'(2));
    rst = 1'b1;
    addr_q.delete();
    mask_q.delete();
    #1;
    chk_zero("midrun_rst");
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("stale_xfer", 32'(x_cnt), 32'(0));
    chk("stale_valid", 32'(blk_valid), 32'(0));
    chk("stale_busy", 32'(busy), 32'(0));
    launch(600, 3);
    finish_run(3, 50);

    // Full-bank run exercises the wide counters.
    launch(1000, D);
    finish_run(D, 3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
